theta_stage: RTL and testbench

// - Column-parity mixing stage for the 5x5x64 matrix encoder; sits directly upstream of the slice swap (pi) stage.
// - Buffers one full state of 64 slices of 25 bits, arriving one slice per handshake.
// - Applies a'[x][y][z] = a[x][y][z] ^ C[x-1][z] ^ C[x+1][z-1], where C[x][z] = XOR over y of a[x][y][z].
// - Streams the result out, one slice per handshake, in slice order 0..63.

---
 rtl/matrix_pkg.sv | 28 ++
 rtl/theta_mix.sv | 24 ++
 rtl/theta_stage.sv | 101 ++++++++++
 tb/tb_theta_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and slice helpers for the 5x5x64 matrix encoder stages.
// Slice bit i maps to lane x = i%5, y = i/5.
package matrix_pkg;

  localparam int SLICE_W  = 25;
  localparam int N_SLICES = 64;
  localparam int SLICE_AW = $clog2(N_SLICES);

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  function automatic logic [4:0] xy2bit(input int x, input int y);
    return 5'(5 * y + x);
  endfunction

  // XOR of the five rows gives the five column parities C[x].
  function automatic logic [4:0] col_parity(input logic [SLICE_W-1:0] slice);
    logic [4:0] p;
    p = '0;
    for (int y = 0; y < 5; y++) begin
      p = p ^ 5'(slice >> (5 * y));
    end
    return p;
  endfunction

endpackage

// File: rtl/theta_mix.sv
// Combinational theta mixing of one slice given its own column parities and those of slice z-1.
module theta_mix
  import matrix_pkg::*;
(
  input  logic [SLICE_W-1:0] i_slice,
  input  logic [4:0]         i_par_cur,
  input  logic [4:0]         i_par_prev,
  output logic [SLICE_W-1:0] o_mixed
);

  logic [4:0] w_d;

  // D[x] = C[x-1][z] ^ C[x+1][z-1], indices mod 5.
  for (genvar x = 0; x < 5; x++) begin : g_d
    assign w_d[x] = i_par_cur[(x + 4) % 5] ^ i_par_prev[(x + 1) % 5];
  end

  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_col
      assign o_mixed[xy2bit(x, y)] = i_slice[xy2bit(x, y)] ^ w_d[x];
    end
  end

endmodule

// File: rtl/theta_stage.sv
// Theta column-parity mixing stage: buffers a full 64-slice state, then streams mixed slices 0..63.
// Optional macro THETA_PARITY_OUT_EN adds out_parity, the unmixed column parities of the emitted slice.
module theta_stage
  import matrix_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SLICE_W-1:0]  in_slice,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SLICE_W-1:0]  out_slice,
  output logic [SLICE_AW-1:0] out_idx,
  output logic                busy
`ifdef THETA_PARITY_OUT_EN
  ,
  output logic [4:0]          out_parity
`endif
);

  localparam int W     = SLICE_W;
  localparam int DEPTH = N_SLICES;
  localparam int AW    = SLICE_AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [AW-1:0]   r_wr_cnt;
  logic [AW-1:0]   r_rd_cnt;
  logic [AW-1:0]   w_rd_prev;
  logic [W-1:0]    r_mem [DEPTH];
  logic [4:0]      r_par [DEPTH];
  logic            w_wr_en;
  logic            w_rd_en;
  logic [W-1:0]    w_mixed;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_wr_cnt == LAST)) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (r_rd_cnt == LAST)) w_next_state = ST_LOAD;
      end
      default: w_next_state = ST_LOAD;
    endcase
  end

  assign w_wr_en = in_valid && in_ready;
  assign w_rd_en = out_valid && out_ready;

  // Counters are AW wide, so incrementing past DEPTH-1 wraps to 0 on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + AW'(1);
      if (w_rd_en) r_rd_cnt <= r_rd_cnt + AW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; every entry is rewritten before DRAIN reads it.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_cnt] <= in_slice;
      r_par[r_wr_cnt] <= col_parity(in_slice);
    end
  end

  assign w_rd_prev = r_rd_cnt - AW'(1);

  theta_mix u_mix (
    .i_slice    (r_mem[r_rd_cnt]),
    .i_par_cur  (r_par[r_rd_cnt]),
    .i_par_prev (r_par[w_rd_prev]),
    .o_mixed    (w_mixed)
  );

  assign out_slice = out_valid ? w_mixed : '0;
  assign out_idx   = r_rd_cnt;
  assign busy      = (r_state == ST_DRAIN) || (r_wr_cnt != '0);

`ifdef THETA_PARITY_OUT_EN
  assign out_parity = out_valid ? r_par[r_rd_cnt] : 5'd0;
`endif

endmodule

// File: tb/tb_theta_stage.sv
// Directed self-checking bench for theta_stage; define THETA_PARITY_OUT_EN to also check out_parity.
module tb_theta_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_slice;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_slice;
  logic [5:0]  out_idx;
  logic        busy;
`ifdef THETA_PARITY_OUT_EN
  logic [4:0]  out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] tb_mem  [64];
  logic [24:0] exp_out [64];
  logic [4:0]  exp_par [64];

  always #5 clk = ~clk;

  theta_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slice  (in_slice),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .out_idx   (out_idx),
    .busy      (busy)
`ifdef THETA_PARITY_OUT_EN
    ,
    .out_parity(out_parity)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_vectors();
    for (int z = 0; z < 64; z++) begin
      tb_mem[z]  = '0;
      exp_out[z] = '0;
      exp_par[z] = '0;
    end
  endtask

  // Reference theta: column fold, then rotate parities of z and z-1 and replicate across rows.
  task automatic model();
    logic [4:0] c [64];
    logic [4:0] d;
    int zp;
    for (int z = 0; z < 64; z++) begin
      c[z] = tb_mem[z][4:0] ^ tb_mem[z][9:5] ^ tb_mem[z][14:10] ^
             tb_mem[z][19:15] ^ tb_mem[z][24:20];
    end
    for (int z = 0; z < 64; z++) begin
      zp = (z + 63) % 64;
      d  = {c[z][3:0], c[z][4]} ^ {c[zp][0], c[zp][4:1]};
      exp_out[z] = tb_mem[z] ^ {5{d}};
      exp_par[z] = c[z];
    end
  endtask

  task automatic load_state(input string tag, input int n);
    for (int z = 0; z < n; z++) begin
      in_valid = 1'b1;
      in_slice = tb_mem[z];
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      if (z == 63) check({tag, "_no_early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_slice = '0;
    if (n == 64) check({tag, "_first_valid_latency"}, 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input string tag, input bit rand_stall, input bit hold_valid);
    int          k = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [24:0] prev_slice = '0;
    logic [5:0]  prev_idx = '0;
    in_valid = hold_valid;
    in_slice = 25'h1abcdef;
    while (k < 64 && cyc < 2000) begin
      out_ready = rand_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (stalled) begin
        check({tag, "_stall_slice_stable"}, 32'(out_slice), 32'(prev_slice));
        check({tag, "_stall_idx_stable"}, 32'(out_idx), 32'(prev_idx));
      end
      check({tag, "_out_idx"}, 32'(out_idx), 32'(k));
      check({tag, "_out_slice"}, 32'(out_slice), 32'(exp_out[k]));
`ifdef THETA_PARITY_OUT_EN
      check({tag, "_out_parity"}, 32'(out_parity), 32'(exp_par[k]));
`endif
      stalled    = !out_ready;
      prev_slice = out_slice;
      prev_idx   = out_idx;
      tick();
      if (out_ready) k++;
      cyc++;
    end
    check({tag, "_drained_all"}, 32'(k), 32'd64);
    in_valid  = 1'b0;
    in_slice  = '0;
    out_ready = 1'b0;
    check({tag, "_back_to_load_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_back_to_load_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_back_to_load_busy"}, 32'(busy), 32'd0);
    check({tag, "_back_to_load_idx"}, 32'(out_idx), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_slice  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_idx", 32'(out_idx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
`ifdef THETA_PARITY_OUT_EN
    check("reset_out_parity", 32'(out_parity), 32'd0);
`endif
    rst = 1'b0;

    // All-zero state streams 64 zero slices.
    clear_vectors();
    load_state("zero", 64);
    drain("zero", 1'b0, 1'b0);

    // Single bit at x=0,y=0 of slice 0 spreads into x=1 of z0 and x=4 of z1.
    clear_vectors();
    tb_mem[0]  = 25'h0000001;
    exp_out[0] = 25'h0210843;
    exp_out[1] = 25'h1084210;
    exp_par[0] = 5'b00001;
    load_state("s0", 64);
    drain("s0", 1'b0, 1'b0);

    // Same bit in slice 63 wraps its z-1 contribution into slice 0.
    clear_vectors();
    tb_mem[63]  = 25'h0000001;
    exp_out[63] = 25'h0210843;
    exp_out[0]  = 25'h1084210;
    exp_par[63] = 5'b00001;
    load_state("wrap", 64);
`ifdef THETA_PARITY_OUT_EN
    check("load_out_parity_zero", 32'(out_parity), 32'd0);
`endif
    drain("wrap", 1'b0, 1'b0);

    // Pseudo-random state with random back-pressure and upstream pushing throughout.
    clear_vectors();
    for (int z = 0; z < 64; z++) tb_mem[z] = 25'($urandom);
    model();
    load_state("bp", 64);
    drain("bp", 1'b1, 1'b1);

    // Reset mid-load discards the partial state.
    clear_vectors();
    for (int z = 0; z < 64; z++) tb_mem[z] = 25'($urandom);
    load_state("partial", 30);
    check("partial_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_idx", 32'(out_idx), 32'd0);
    for (int z = 0; z < 64; z++) tb_mem[z] = 25'($urandom);
    model();
    load_state("fresh", 64);
    drain("fresh", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
